// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one synchronous imem read per
// cycle when credit allows, and queues {pc, inst} pairs for decode in a small FIFO.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          ADDR_W   = 10,
  parameter int          DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  output logic [31:0]       fetch_pc,
  output logic              align_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [CW-1:0] count;
  logic          inflight;
  logic [31:0]   resp_pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [CW:0]   used;
  logic          push;
  logic          pop;

  // Handshake: the head transfers on any rising edge where out_valid && out_ready are both
  // high; out_valid never depends on out_ready, and the head is held while stalled.
  // A request is issued only when every FIFO slot not yet full has room for an in-flight
  // response, so a pushed response can never find the FIFO full.
  assign used      = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req  = !rst && !redirect_valid && (used < DEPTH_C);
  assign imem_addr = fetch_pc[ADDR_W+1:2];

  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? pc_mem[rd_ptr]   : 32'h0;
  assign out_inst  = out_valid ? inst_mem[rd_ptr] : 32'h0;

  // A redirect kills the response arriving this cycle along with everything queued.
  assign push = inflight && !redirect_valid;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      inflight  <= 1'b0;
      resp_pc   <= 32'h0;
      align_err <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc  <= {redirect_pc[31:2], 2'b00};
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      inflight  <= 1'b0;
      align_err <= align_err | (redirect_pc[1:0] != 2'b00);
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        resp_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      inst_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference of the fetch stream checked every cycle,
// plus directed scenarios with literal expectations at key cycles.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int          ADDR_W   = 10;
  localparam int          DEPTH    = 4;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic              out_ready = 1'b1;
  logic [31:0]       imem_rdata = 32'h0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              out_valid;
  logic [31:0]       out_inst;
  logic [31:0]       out_pc;
  logic [31:0]       fetch_pc;
  logic              align_err;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .fetch_pc(fetch_pc), .align_err(align_err)
  );

  // Instruction memory contents: distinct, address-derived words.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {6'h2a, a, ~a, 6'h15};
  endfunction

  always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req_v, $time);
    end
  endtask

  // Reference: queue of PCs awaiting decode, one in-flight slot, and the fetch PC.
  logic [31:0] exp_q[$];
  logic        m_infl = 1'b0;
  logic [31:0] m_infl_pc = 32'h0;
  logic [31:0] m_pc = RESET_PC;
  logic        m_align = 1'b0;
  bit          checking = 1'b0;

  function automatic bit model_req();
    return !rst && !redirect_valid && ((exp_q.size() + int'(m_infl)) < DEPTH);
  endfunction

  always @(posedge clk) begin : model_blk
    bit req;
    req = model_req();
    if (rst) begin
      exp_q.delete();
      m_infl  = 1'b0;
      m_pc    = RESET_PC;
      m_align = 1'b0;
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (redirect_valid) begin
        exp_q.delete();
        m_infl = 1'b0;
        m_pc   = {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) m_align = 1'b1;
      end else begin
        if (m_infl) exp_q.push_back(m_infl_pc);
        m_infl = req;
        if (req) begin
          m_infl_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end
      end
    end
    checking = 1'b1;
  end

  always @(negedge clk) begin : compare_blk
    bit          ev;
    logic [31:0] hp;
    logic [ADDR_W-1:0] ha;
    if (checking) begin
      ev = (exp_q.size() != 0);
      hp = ev ? exp_q[0] : 32'h0;
      ha = hp[ADDR_W+1:2];
      check("out_valid", {31'd0, out_valid}, {31'd0, ev});
      check("out_pc", out_pc, hp);
      check("out_inst", out_inst, ev ? mem_word(ha) : 32'h0);
      check("imem_req", {31'd0, imem_req}, {31'd0, model_req()});
      check("fetch_pc", fetch_pc, m_pc);
      check("align_err", {31'd0, align_err}, {31'd0, m_align});
      if (model_req()) check("imem_addr", {22'd0, imem_addr}, {22'd0, m_pc[ADDR_W+1:2]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic cycles(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic restart(input logic rdy);
    next_cycle();
    rst = 1'b1;
    out_ready = rdy;
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    cycles(3);
    rst = 1'b0;

    // Streaming from reset with decode always ready.
    at_neg();
    check("t1_req_c0", {31'd0, imem_req}, 32'd1);
    check("t1_addr_c0", {22'd0, imem_addr}, 32'd0);
    next_cycle(); at_neg();
    check("t1_valid_c1", {31'd0, out_valid}, 32'd0);
    check("t1_addr_c1", {22'd0, imem_addr}, 32'd1);
    next_cycle(); at_neg();
    check("t1_valid_c2", {31'd0, out_valid}, 32'd1);
    check("t1_pc_c2", out_pc, 32'h1c000000);
    check("t1_inst_c2", out_inst, 32'ha800ffd5);
    next_cycle(); at_neg();
    check("t1_pc_c3", out_pc, 32'h1c000004);
    next_cycle(); at_neg();
    check("t1_pc_c4", out_pc, 32'h1c000008);
    check("t1_addr_c4", {22'd0, imem_addr}, 32'd4);

    // Backpressure fills the FIFO, then drains contiguously.
    restart(1'b0);
    cycles(10); at_neg();
    check("t2_valid_full", {31'd0, out_valid}, 32'd1);
    check("t2_head_full", out_pc, 32'h1c000000);
    check("t2_req_full", {31'd0, imem_req}, 32'd0);
    check("t2_fetch_pc", fetch_pc, 32'h1c000010);
    next_cycle();
    out_ready = 1'b1;
    at_neg();
    check("t2_drain0", out_pc, 32'h1c000000);
    next_cycle(); at_neg();
    check("t2_drain1", out_pc, 32'h1c000004);
    cycles(3); at_neg();
    check("t2_drain4", out_pc, 32'h1c000010);

    // Redirect with three queued and one in flight.
    restart(1'b0);
    cycles(4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c000100;
    at_neg();
    check("t3_req_t", {31'd0, imem_req}, 32'd0);
    check("t3_head_t", out_pc, 32'h1c000000);
    next_cycle();
    redirect_valid = 1'b0;
    at_neg();
    check("t3_valid_t1", {31'd0, out_valid}, 32'd0);
    check("t3_req_t1", {31'd0, imem_req}, 32'd1);
    check("t3_addr_t1", {22'd0, imem_addr}, 32'h40);
    next_cycle(); at_neg();
    check("t3_valid_t2", {31'd0, out_valid}, 32'd0);
    next_cycle(); at_neg();
    check("t3_valid_t3", {31'd0, out_valid}, 32'd1);
    check("t3_pc_t3", out_pc, 32'h1c000100);

    // Misaligned redirect: low bits dropped, sticky error.
    next_cycle();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c000102;
    next_cycle();
    redirect_valid = 1'b0;
    at_neg();
    check("t4_align_t1", {31'd0, align_err}, 32'd1);
    check("t4_fetch_pc", fetch_pc, 32'h1c000100);
    cycles(2); at_neg();
    check("t4_pc_t3", out_pc, 32'h1c000100);
    cycles(5); at_neg();
    check("t4_align_held", {31'd0, align_err}, 32'd1);

    // Back-to-back redirects: only the second target survives.
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c000040;
    next_cycle();
    redirect_pc = 32'h1c000080;
    next_cycle();
    redirect_valid = 1'b0;
    next_cycle(); at_neg();
    check("t5_valid_t3", {31'd0, out_valid}, 32'd0);
    next_cycle(); at_neg();
    check("t5_pc_t4", out_pc, 32'h1c000080);

    // Fetch PC wraps past the top of the address space.
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'hfffffff8;
    next_cycle();
    redirect_valid = 1'b0;
    cycles(2); at_neg();
    check("wrap_pc_t3", out_pc, 32'hfffffff8);
    check("wrap_fetch_t3", fetch_pc, 32'h0);
    next_cycle(); at_neg();
    check("wrap_pc_t4", out_pc, 32'hfffffffc);
    next_cycle(); at_neg();
    check("wrap_pc_t5", out_pc, 32'h0);
    check("wrap_inst_t5", out_inst, 32'ha800ffd5);

    // Reset wins over a simultaneous redirect and pop.
    next_cycle();
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c000046;
    out_ready = 1'b1;
    at_neg();
    check("t6_req_rst", {31'd0, imem_req}, 32'd0);
    next_cycle();
    rst = 1'b0;
    redirect_valid = 1'b0;
    at_neg();
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    check("t6_align", {31'd0, align_err}, 32'd0);
    check("t6_fetch_pc", fetch_pc, 32'h1c000000);
    cycles(2); at_neg();
    check("t6_pc", out_pc, 32'h1c000000);

    cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
